// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: issue/writeback bundle between id_stage, the scoreboard and wb.
//   master: decoder/pipeline side; drives instruction info, writeback info, ser_done, flush.
//   slave : scoreboard side; drives id_ready, issue_fire, stall, busy_vec, inflight, state.
interface id_scoreboard_if #(
  parameter int unsigned CNT_W = 3
) ();
  logic             id_valid;
  logic             id_ready;
  logic             rs1_r_ena;
  logic [4:0]       rs1_r_addr;
  logic             rs2_r_ena;
  logic [4:0]       rs2_r_addr;
  logic             rd_w_ena;
  logic [4:0]       rd_w_addr;
  logic             id_serial;
  logic             wb_w_ena;
  logic [4:0]       wb_w_addr;
  logic             ser_done;
  logic             flush;
  logic             issue_fire;
  logic             stall;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] inflight;
  logic [1:0]       state;

  modport master (
    output id_valid, rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr, rd_w_ena, rd_w_addr,
           id_serial, wb_w_ena, wb_w_addr, ser_done, flush,
    input  id_ready, issue_fire, stall, busy_vec, inflight, state
  );

  modport slave (
    input  id_valid, rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr, rd_w_ena, rd_w_addr,
           id_serial, wb_w_ena, wb_w_addr, ser_done, flush,
    output id_ready, issue_fire, stall, busy_vec, inflight, state
  );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: issue controller between id_stage and ex_stage.
//   Tracks in-flight GPR writes in a 32-entry busy vector, stalls on RAW/WAW hazards,
//   serialises CSR/fence/system instructions behind a drained pipeline, and clears all
//   state on flush.
// Ports:
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : id_scoreboard_if.slave (instruction/writeback inputs, ready/stall/status outputs)
module id_scoreboard #(
  parameter int unsigned CNT_W     = 3,
  parameter bit          WB_BYPASS = 1'b1
) (
  input logic           clk,
  input logic           rst,
  id_scoreboard_if.slave bus
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StSerial = 2'd2;

  localparam logic [CNT_W-1:0] MaxCnt = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [1:0]       state_q, state_d;

  logic [31:0] wb_hit;
  logic [31:0] rel_vec;
  logic        retire;
  logic        rd_tracked;
  logic        hazard;
  logic        drain_done;
  logic        ready;
  logic        fire;
  logic        set_track;

  always_comb begin
    // With bypass, the register being written back this cycle no longer blocks readers/writers.
    wb_hit = '0;
    if (WB_BYPASS && bus.wb_w_ena) wb_hit[bus.wb_w_addr] = 1'b1;
    rel_vec = busy_q & ~wb_hit;

    retire     = bus.wb_w_ena && (bus.wb_w_addr != 5'd0) && busy_q[bus.wb_w_addr];
    rd_tracked = bus.rd_w_ena && (bus.rd_w_addr != 5'd0);

    hazard = (bus.rs1_r_ena && rel_vec[bus.rs1_r_addr])
          || (bus.rs2_r_ena && rel_vec[bus.rs2_r_addr])
          || (rd_tracked && rel_vec[bus.rd_w_addr])
          || (rd_tracked && (inflight_q == MaxCnt) && !retire);

    // Pipeline counts as drained when the last outstanding write retires this cycle.
    drain_done = (inflight_q == '0) || (WB_BYPASS && retire && (inflight_q == OneCnt));

    ready   = 1'b0;
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (bus.id_serial) begin
          ready = (inflight_q == '0) && !hazard;
          if (bus.id_valid) state_d = ready ? StSerial : StDrain;
        end else begin
          ready = !hazard;
        end
      end
      StDrain: begin
        ready = drain_done && !hazard;
        if (!bus.id_valid)  state_d = StRun;
        else if (ready)     state_d = StSerial;
      end
      StSerial: begin
        if (bus.ser_done) state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    if (bus.flush || !rst) ready = 1'b0;

    fire      = bus.id_valid && ready;
    set_track = fire && rd_tracked;

    // Clear first, then set, so a new writer wins over a same-cycle retire of that register.
    busy_d = busy_q;
    if (retire)    busy_d[bus.wb_w_addr] = 1'b0;
    if (set_track) busy_d[bus.rd_w_addr] = 1'b1;
    busy_d[0] = 1'b0;

    inflight_d = inflight_q;
    case ({set_track, retire})
      2'b10:   inflight_d = inflight_q + OneCnt;
      2'b01:   inflight_d = inflight_q - OneCnt;
      default: inflight_d = inflight_q;
    endcase

    if (bus.flush) begin
      busy_d     = '0;
      inflight_d = '0;
      state_d    = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
      state_q    <= StRun;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  assign bus.id_ready   = ready;
  assign bus.issue_fire = fire;
  assign bus.stall      = bus.id_valid && !ready && rst;
  assign bus.busy_vec   = busy_q;
  assign bus.inflight   = inflight_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: table-driven bench for id_scoreboard (CNT_W=3, WB_BYPASS=1).
module tb_id_scoreboard;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] SERIAL = 2'd2;

  typedef struct {
    logic        valid;
    logic        serial;
    logic        rs1e;
    logic [4:0]  rs1;
    logic        rs2e;
    logic [4:0]  rs2;
    logic        rde;
    logic [4:0]  rd;
    logic        wbe;
    logic [4:0]  wba;
    logic        sdone;
    logic        flush;
    logic        rdy;       // expected id_ready this cycle
    logic [31:0] busy;      // expected busy_vec after the edge
    logic [2:0]  infl;      // expected inflight after the edge
    logic [1:0]  st;        // expected state after the edge
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  id_scoreboard_if #(.CNT_W(3)) bus ();

  id_scoreboard #(.CNT_W(3), .WB_BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Column order: valid serial rs1e rs1 rs2e rs2 rde rd wbe wba sdone flush | rdy busy infl st
  task automatic add(input int v, input int s, input int r1e, input int r1, input int r2e,
                     input int r2, input int de, input int d, input int we, input int wa,
                     input int sd, input int fl, input int rdy, input logic [31:0] busy,
                     input int infl, input logic [1:0] st);
    vec_t t;
    t.valid = 1'(v);   t.serial = 1'(s);
    t.rs1e  = 1'(r1e); t.rs1    = 5'(r1);
    t.rs2e  = 1'(r2e); t.rs2    = 5'(r2);
    t.rde   = 1'(de);  t.rd     = 5'(d);
    t.wbe   = 1'(we);  t.wba    = 5'(wa);
    t.sdone = 1'(sd);  t.flush  = 1'(fl);
    t.rdy   = 1'(rdy); t.busy   = busy;
    t.infl  = 3'(infl); t.st    = st;
    tbl.push_back(t);
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid   = v.valid;
    bus.id_serial  = v.serial;
    bus.rs1_r_ena  = v.rs1e;
    bus.rs1_r_addr = v.rs1;
    bus.rs2_r_ena  = v.rs2e;
    bus.rs2_r_addr = v.rs2;
    bus.rd_w_ena   = v.rde;
    bus.rd_w_addr  = v.rd;
    bus.wb_w_ena   = v.wbe;
    bus.wb_w_addr  = v.wba;
    bus.ser_done   = v.sdone;
    bus.flush      = v.flush;
  endtask

  // Called just after a rising edge: drive, check combinational outputs mid-cycle,
  // then check registered outputs just after the next edge.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q[0];
    chk("id_ready", idx, 32'(bus.id_ready), 32'(e.rdy));
    chk("issue_fire", idx, 32'(bus.issue_fire), 32'(e.valid & e.rdy));
    chk("stall", idx, 32'(bus.stall), 32'(e.valid & ~e.rdy));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("busy_vec", idx, bus.busy_vec, e.busy);
    chk("inflight", idx, 32'(bus.inflight), 32'(e.infl));
    chk("state", idx, 32'(bus.state), 32'(e.st));
  endtask

  initial begin
    vec_t        idle;
    logic [31:0] b;

    // RAW on x5, bypass fire in the wb cycle
    add(1,0, 0,0, 0,0, 1,5, 0,0, 0,0, 1, 32'h20, 1, RUN);
    add(1,0, 1,5, 1,1, 1,6, 0,0, 0,0, 0, 32'h20, 1, RUN);
    add(1,0, 1,5, 1,1, 1,6, 1,5, 0,0, 1, 32'h40, 1, RUN);
    add(0,0, 0,0, 0,0, 0,0, 1,6, 0,0, 1, 32'h0,  0, RUN);
    // WAW on x7 with same-cycle retire: set wins, count unchanged
    add(1,0, 0,0, 0,0, 1,7, 0,0, 0,0, 1, 32'h80, 1, RUN);
    add(1,0, 0,0, 0,0, 1,7, 1,7, 0,0, 1, 32'h80, 1, RUN);
    add(0,0, 0,0, 0,0, 0,0, 1,7, 0,0, 1, 32'h0,  0, RUN);
    // retire of a non-busy register is ignored
    add(0,0, 0,0, 0,0, 0,0, 1,9, 0,0, 1, 32'h0,  0, RUN);
    // fill to max outstanding with x1..x7
    b = 32'h0;
    for (int i = 1; i <= 7; i++) begin
      b[i] = 1'b1;
      add(1,0, 0,0, 0,0, 1,i, 0,0, 0,0, 1, b, i, RUN);
    end
    add(1,0, 0,0, 0,0, 1,8, 0,0, 0,0, 0, 32'hFE,  7, RUN);
    add(1,0, 0,0, 0,0, 1,8, 1,1, 0,0, 1, 32'h1FC, 7, RUN);
    add(1,0, 1,0, 0,0, 1,0, 0,0, 0,0, 1, 32'h1FC, 7, RUN);  // x0 write not tracked
    add(1,0, 0,0, 1,3, 0,0, 0,0, 0,0, 0, 32'h1FC, 7, RUN);  // rs2 RAW
    b = 32'h1FC;
    for (int i = 2; i <= 6; i++) begin
      b[i] = 1'b0;
      add(0,0, 0,0, 0,0, 0,0, 1,i, 0,0, 1, b, 8 - i, RUN);
    end
    // serial with inflight=2: drain, fire on last retire, serial, ser_done
    add(1,1, 1,1, 0,0, 0,0, 0,0, 0,0, 0, 32'h180, 2, DRAIN);
    add(1,1, 1,1, 0,0, 0,0, 0,0, 0,0, 0, 32'h180, 2, DRAIN);
    add(1,1, 1,1, 0,0, 0,0, 1,7, 0,0, 0, 32'h100, 1, DRAIN);
    add(1,1, 1,1, 0,0, 0,0, 1,8, 0,0, 1, 32'h0,   0, SERIAL);
    add(1,0, 0,0, 0,0, 1,11, 0,0, 0,0, 0, 32'h0,  0, SERIAL);
    add(1,0, 0,0, 0,0, 1,11, 0,0, 1,0, 0, 32'h0,  0, RUN);
    add(1,0, 0,0, 0,0, 1,11, 0,0, 0,0, 1, 32'h800, 1, RUN);
    add(0,0, 0,0, 0,0, 0,0, 0,0, 1,0, 1, 32'h800, 1, RUN);  // ser_done outside SERIAL
    // DRAIN abandoned when id_valid drops
    add(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 32'h800, 1, DRAIN);
    add(0,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 32'h800, 1, RUN);
    add(0,0, 0,0, 0,0, 0,0, 1,11, 0,0, 1, 32'h0,  0, RUN);
    // serial on an already-drained pipeline fires immediately
    add(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 1, 32'h0, 0, SERIAL);
    add(0,0, 0,0, 0,0, 0,0, 0,0, 1,0, 0, 32'h0, 0, RUN);
    // serial writer of x5 while x7 retires, then flush in SERIAL
    add(1,0, 0,0, 0,0, 1,7, 0,0, 0,0, 1, 32'h80, 1, RUN);
    add(1,1, 0,0, 0,0, 1,5, 0,0, 0,0, 0, 32'h80, 1, DRAIN);
    add(1,1, 0,0, 0,0, 1,5, 1,7, 0,0, 1, 32'h20, 1, SERIAL);
    add(0,0, 0,0, 0,0, 0,0, 1,5, 1,1, 0, 32'h0,  0, RUN);
    // flush with busy=0xA0, inflight=2 overrides a fire and a retire
    add(1,0, 0,0, 0,0, 1,5, 0,0, 0,0, 1, 32'h20, 1, RUN);
    add(1,0, 0,0, 0,0, 1,7, 0,0, 0,0, 1, 32'hA0, 2, RUN);
    add(1,0, 0,0, 0,0, 1,9, 1,5, 0,1, 0, 32'h0,  0, RUN);
    // setup for async reset mid-DRAIN
    add(1,0, 0,0, 0,0, 1,3, 0,0, 0,0, 1, 32'h8, 1, RUN);
    add(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 32'h8, 1, DRAIN);

    idle = '{default: '0};

    // Reset state with a would-be instruction present
    drive(idle);
    bus.id_valid = 1'b1;
    bus.rd_w_ena = 1'b1;
    bus.rd_w_addr = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst id_ready", 0, 32'(bus.id_ready), 32'd0);
    chk("rst issue_fire", 0, 32'(bus.issue_fire), 32'd0);
    chk("rst stall", 0, 32'(bus.stall), 32'd0);
    chk("rst busy_vec", 0, bus.busy_vec, 32'd0);
    chk("rst inflight", 0, 32'(bus.inflight), 32'd0);
    chk("rst state", 0, 32'(bus.state), 32'(RUN));
    drive(idle);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Asynchronous reset asserted mid-cycle while in DRAIN
    #2;
    rst = 1'b0;
    #1;
    chk("async id_ready", 100, 32'(bus.id_ready), 32'd0);
    chk("async issue_fire", 100, 32'(bus.issue_fire), 32'd0);
    chk("async stall", 100, 32'(bus.stall), 32'd0);
    chk("async busy_vec", 100, bus.busy_vec, 32'd0);
    chk("async inflight", 100, 32'(bus.inflight), 32'd0);
    chk("async state", 100, 32'(bus.state), 32'(RUN));
    @(negedge clk);
    drive(idle);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst busy_vec", 101, bus.busy_vec, 32'd0);
    chk("post-rst state", 101, 32'(bus.state), 32'(RUN));
    tbl.delete();
    add(1,0, 0,0, 0,0, 1,4, 0,0, 0,0, 1, 32'h10, 1, RUN);
    run_vec(tbl[0], 102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
